// File: rtl/instr_stream_player_pkg.sv
// Shared types and sizing for the instruction stream player.
package instr_stream_player_pkg;

    localparam int DEPTH   = 16;               // step table entries (power of 2)
    localparam int AW      = $clog2(DEPTH);
    localparam int DATA_W  = 8;                // imm / dataout / expected width
    localparam int NUM_CH  = 4;                // processor output channels
    localparam int WAIT_W  = 4;                // per-step wait count width
    localparam int TIMEOUT = 8;                // max CHECK cycles without valid
    localparam int CNT_W   = 8;                // saturating pass/fail counters
    localparam int CH_W    = 3;                // wide enough to name a bad channel
    localparam int TO_W    = $clog2(TIMEOUT);  // counts 0..TIMEOUT-1

    typedef enum logic [2:0] {
        NOP = 3'd0,
        LD  = 3'd1,
        OUT = 3'd2,
        ADD = 3'd3,
        SUB = 3'd4
    } opcode_t;

    typedef enum logic [2:0] {
        IMM = 3'd0,
        R0  = 3'd1,
        R1  = 3'd2,
        R2  = 3'd3,
        R3  = 3'd4
    } reg_t;

    typedef struct packed {
        opcode_t             opcode;
        reg_t                src1;
        reg_t                src2;
        reg_t                dst;
        logic [DATA_W-1:0]   imm;
        logic [WAIT_W-1:0]   wait_cyc;
        logic                chk_en;
        logic [CH_W-1:0]     chk_ch;
        logic [DATA_W-1:0]   exp_val;
        logic                last;
    } step_t;

    localparam int STEP_W = $bits(step_t);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } player_state_t;

endpackage

// File: rtl/instr_stream_player_step_ram.sv
// Step table: one write port, one registered read port.
module instr_stream_player_step_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Table write port.
    // NOTE: the storage array is deliberately left without reset so it maps onto plain RAM;
    // only the read register below is reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when not enabled.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_stream_player.sv
// Program player: fetches steps, issues one instruction per step, waits,
// optionally checks a processor output channel and tallies pass/fail.
module instr_stream_player
    import instr_stream_player_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     prog_we,
    input  logic [AW-1:0]            prog_addr,
    input  step_t                    prog_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [AW-1:0]            first_fail,
    output logic                     instv,
    output opcode_t                  opcode,
    output reg_t                     src1,
    output reg_t                     src2,
    output reg_t                     dst,
    output logic [DATA_W-1:0]        imm,
    input  logic [NUM_CH*DATA_W-1:0] dataout,
    input  logic [NUM_CH-1:0]        dataoutv
);

    localparam int CI_W = $clog2(NUM_CH);

    player_state_t       state_q, state_d;
    step_t               step_q;
    logic [AW-1:0]       ptr;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [TO_W-1:0]     chk_cnt;
    logic                start_ok, step_end, do_pass, do_fail;
    logic                ch_in_range;
    logic [CI_W-1:0]     ch_idx;
    logic [DATA_W-1:0]   ch_data [NUM_CH];

    // The read register doubles as the step register: it is loaded only in
    // FETCH, so instruction fields stay stable through WAIT/CHECK and DONE.
    instr_stream_player_step_ram #(.DEPTH(DEPTH), .W(STEP_W)) u_step_ram (
        .clock (clock),
        .reset (reset),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (state_q == S_FETCH),
        .raddr (ptr),
        .rdata (step_q)
    );

    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);
    assign instv  = (state_q == S_ISSUE);
    assign opcode = step_q.opcode;
    assign src1   = step_q.src1;
    assign src2   = step_q.src2;
    assign dst    = step_q.dst;
    assign imm    = step_q.imm;

    assign ch_in_range = int'(step_q.chk_ch) < NUM_CH;
    assign ch_idx      = step_q.chk_ch[CI_W-1:0];

    // Split the flat processor output bus into per-channel words.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_data[c] = dataout[c*DATA_W +: DATA_W];
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle check verdicts.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        step_end = 1'b0;
        do_pass  = 1'b0;
        do_fail  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                if (step_q.wait_cyc != '0) state_d = S_WAIT;
                else if (step_q.chk_en)    state_d = S_CHECK;
                else                       step_end = 1'b1;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    if (step_q.chk_en) state_d = S_CHECK;
                    else               step_end = 1'b1;
                end
            end
            S_CHECK: begin
                if (!ch_in_range) begin
                    do_fail  = 1'b1;
                    step_end = 1'b1;
                end else if (dataoutv[ch_idx]) begin
                    do_pass  = (ch_data[ch_idx] == step_q.exp_val);
                    do_fail  = (ch_data[ch_idx] != step_q.exp_val);
                    step_end = 1'b1;
                end else if (chk_cnt == TO_W'(TIMEOUT - 1)) begin
                    do_fail  = 1'b1;
                    step_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The table never wraps: the final entry ends the run like a last bit.
        if (step_end) begin
            state_d = (step_q.last || (&ptr)) ? S_DONE : S_FETCH;
        end
    end

    // Step pointer, wait/check timers and the pass/fail scoreboard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            wait_cnt   <= '0;
            chk_cnt    <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
        end else begin
            if (start_ok) begin
                ptr        <= '0;
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                first_fail <= '0;
            end else if (step_end && (state_d == S_FETCH)) begin
                ptr <= ptr + 1'b1;
            end

            if (state_q == S_ISSUE)     wait_cnt <= step_q.wait_cyc - 1'b1;
            else if (state_q == S_WAIT) wait_cnt <= wait_cnt - 1'b1;

            chk_cnt <= (state_q == S_CHECK) ? chk_cnt + 1'b1 : '0;

            if (do_pass && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
            if (do_fail) begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                if (fail_cnt == '0) first_fail <= ptr;
            end
        end
    end

endmodule
